somador_serial: RTL and testbench

Bit-serial N-bit full adder, the addition counterpart to the team's full subtractor: it loads two operands and a carry-in, then adds them LSB-first through a single full-adder cell and a carry flip-flop, one bit per clock. It sits beside the combinational arithmetic blocks in the arithmetic circuits set. It trades WIDTH cycles of latency for one-bit datapath hardware. A start/busy/done handshake makes it usable from a controller FSM.

---
 rtl/somador_serial_if.sv | 24 ++
 rtl/somador_serial.sv | 108 ++++++++++
 tb/tb_somador_serial.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/somador_serial_if.sv
// rtl/somador_serial_if.sv - handshake and operand/result bundle for somador_serial
interface somador_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, a, b, carry_in,
    input  busy, done, sum, carry_out, overflow
  );

  modport slave (
    input  start, a, b, carry_in,
    output busy, done, sum, carry_out, overflow
  );
endinterface

// File: rtl/somador_serial.sv
// rtl/somador_serial.sv - bit-serial adder, LSB first through one full-adder cell and a carry flop
module somador_serial #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  somador_serial_if.slave   bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic             c_q, c_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;

  logic             s_bit;
  logic             c_next;
  logic [WIDTH-1:0] s_shifted;

  always_comb begin
    state_d     = state_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    s_sr_d      = s_sr_q;
    c_d         = c_q;
    count_d     = count_q;
    sum_d       = sum_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;

    s_bit     = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
    c_next    = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & c_q) | (b_sr_q[0] & c_q);
    s_shifted = {s_bit, s_sr_q[WIDTH-1:1]};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          c_d     = bus.carry_in;
          count_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        s_sr_d  = s_shifted;
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        c_d     = c_next;
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          // c_q is still the carry into the MSB here, so it gives signed overflow.
          sum_d       = s_shifted;
          carry_out_d = c_next;
          overflow_d  = c_q ^ c_next;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      s_sr_q      <= '0;
      c_q         <= 1'b0;
      count_q     <= '0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      s_sr_q      <= s_sr_d;
      c_q         <= c_d;
      count_q     <= count_d;
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.busy      = (state_q == SHIFT);
  assign bus.done      = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_somador_serial.sv
// tb/tb_somador_serial.sv - directed and exhaustive checks of somador_serial at WIDTH 8 and 4
module tb_somador_serial;
  logic clk = 1'b0;
  logic rst;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  somador_serial_if #(.WIDTH(8)) if8 ();
  somador_serial_if #(.WIDTH(4)) if4 ();

  somador_serial #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));
  somador_serial #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts an 8-bit op from IDLE; lat = samples after the accepting edge until done (-1 on timeout).
  task automatic do_op8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        output int lat, output int busyc);
    if8.a = av; if8.b = bv; if8.carry_in = cv; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    lat = -1;
    busyc = 0;
    for (int j = 0; j < 40; j++) begin
      if (if8.done) begin
        lat = j;
        break;
      end
      if (if8.busy) busyc++;
      tick();
    end
  endtask

  task automatic test_reset();
    logic quiet;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total_cnt++;
    if ({if8.sum, if8.carry_out, if8.overflow, if8.busy, if8.done} !== 12'h000) begin
      $display("FAIL reset8: got sum=%h co=%b ov=%b busy=%b done=%b want all 0",
               if8.sum, if8.carry_out, if8.overflow, if8.busy, if8.done);
    end else pass_cnt++;
    total_cnt++;
    if ({if4.sum, if4.carry_out, if4.overflow, if4.busy, if4.done} !== 8'h00) begin
      $display("FAIL reset4: got sum=%h co=%b ov=%b busy=%b done=%b want all 0",
               if4.sum, if4.carry_out, if4.overflow, if4.busy, if4.done);
    end else pass_cnt++;
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (if8.busy || if8.done || if8.sum !== 8'h00 || if4.busy || if4.done) quiet = 1'b0;
    end
    total_cnt++;
    if (quiet !== 1'b1) $display("FAIL idle_hold: activity seen with start=0, got %b want 1", quiet);
    else pass_cnt++;
  endtask

  task automatic test_vectors();
    logic [7:0] va [6] = '{8'h00, 8'hFF, 8'h7F, 8'h80, 8'h0F, 8'h64};
    logic [7:0] vb [6] = '{8'h00, 8'h01, 8'h01, 8'h80, 8'hF0, 8'h64};
    logic       vc [6] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0};
    logic [7:0] es [6] = '{8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'hC8};
    logic       ec [6] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0};
    logic       eo [6] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1};
    int lat, busyc;
    for (int i = 0; i < 6; i++) begin
      do_op8(va[i], vb[i], vc[i], lat, busyc);
      total_cnt++;
      if ({if8.sum, if8.carry_out, if8.overflow} !== {es[i], ec[i], eo[i]}) begin
        $display("FAIL vec%0d %h+%h+%b: got sum=%h co=%b ov=%b want sum=%h co=%b ov=%b", i,
                 va[i], vb[i], vc[i], if8.sum, if8.carry_out, if8.overflow, es[i], ec[i], eo[i]);
      end else pass_cnt++;
      total_cnt++;
      if (lat !== 8 || busyc !== 8)
        $display("FAIL timing%0d: got done_at=%0d busy_cycles=%0d want 8 and 8", i, lat, busyc);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (if8.done !== 1'b0 || if8.busy !== 1'b0)
        $display("FAIL pulse%0d: got done=%b busy=%b after done want 0 0", i, if8.done, if8.busy);
      else pass_cnt++;
    end
  endtask

  task automatic test_start_ignored();
    int  lat;
    logic quiet;
    if8.a = 8'h12; if8.b = 8'h34; if8.carry_in = 1'b0; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    tick(); tick(); tick();
    if8.a = 8'hFF; if8.b = 8'hFF; if8.carry_in = 1'b1; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    lat = -1;
    for (int j = 0; j < 30; j++) begin
      if (if8.done) begin lat = j; break; end
      tick();
    end
    total_cnt++;
    if (lat < 0 || {if8.sum, if8.carry_out, if8.overflow} !== {8'h46, 1'b0, 1'b0})
      $display("FAIL start_ignored: got sum=%h co=%b ov=%b done_at=%0d want sum=46 co=0 ov=0",
               if8.sum, if8.carry_out, if8.overflow, lat);
    else pass_cnt++;
    quiet = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (if8.busy || if8.done) quiet = 1'b0;
    end
    total_cnt++;
    if (quiet !== 1'b1) $display("FAIL no_queue: got %b want 1 (ignored start ran later)", quiet);
    else pass_cnt++;
  endtask

  task automatic test_operand_change();
    int lat;
    if8.a = 8'h55; if8.b = 8'h22; if8.carry_in = 1'b1; if8.start = 1'b1;
    tick();
    if8.start = 1'b0; if8.a = 8'h00; if8.b = 8'h00; if8.carry_in = 1'b0;
    lat = -1;
    for (int j = 0; j < 30; j++) begin
      if (if8.done) begin lat = j; break; end
      tick();
    end
    total_cnt++;
    if (lat !== 8 || {if8.sum, if8.carry_out, if8.overflow} !== {8'h78, 1'b0, 1'b0})
      $display("FAIL operand_change: got sum=%h co=%b ov=%b done_at=%0d want sum=78 co=0 ov=0 at 8",
               if8.sum, if8.carry_out, if8.overflow, lat);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    int   lat, gap;
    logic held;
    if8.a = 8'h10; if8.b = 8'h20; if8.carry_in = 1'b0; if8.start = 1'b1;
    tick();
    lat = -1;
    for (int j = 0; j < 30; j++) begin
      if (if8.done) begin lat = j; break; end
      tick();
    end
    total_cnt++;
    if (lat !== 8 || if8.sum !== 8'h30)
      $display("FAIL b2b_first: got sum=%h done_at=%0d want sum=30 at 8", if8.sum, lat);
    else pass_cnt++;
    if8.a = 8'h01; if8.b = 8'h02;
    held = 1'b1;
    gap = -1;
    for (int j = 1; j < 30; j++) begin
      tick();
      if (if8.done) begin gap = j; break; end
      if (if8.sum !== 8'h30) held = 1'b0;
    end
    total_cnt++;
    if (gap !== 10) $display("FAIL b2b_gap: got %0d edges between dones want 10", gap);
    else pass_cnt++;
    total_cnt++;
    if (held !== 1'b1) $display("FAIL b2b_hold: got held=%b want 1 (sum changed before done)", held);
    else pass_cnt++;
    total_cnt++;
    if (if8.sum !== 8'h03) $display("FAIL b2b_second: got sum=%h want 03", if8.sum);
    else pass_cnt++;
    if8.start = 1'b0;
    tick();
    tick();
    total_cnt++;
    if (if8.busy !== 1'b0 || if8.done !== 1'b0)
      $display("FAIL b2b_stop: got busy=%b done=%b want 0 0", if8.busy, if8.done);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_op();
    int   lat, busyc;
    logic quiet;
    if8.a = 8'hFF; if8.b = 8'h01; if8.carry_in = 1'b0; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++;
    if ({if8.sum, if8.carry_out, if8.overflow, if8.busy, if8.done} !== 12'h000)
      $display("FAIL reset_mid: got sum=%h co=%b ov=%b busy=%b done=%b want all 0",
               if8.sum, if8.carry_out, if8.overflow, if8.busy, if8.done);
    else pass_cnt++;
    quiet = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (if8.busy || if8.done) quiet = 1'b0;
    end
    total_cnt++;
    if (quiet !== 1'b1) $display("FAIL reset_no_done: got %b want 1", quiet);
    else pass_cnt++;
    do_op8(8'h3C, 8'h44, 1'b0, lat, busyc);
    total_cnt++;
    if (lat !== 8 || {if8.sum, if8.carry_out, if8.overflow} !== {8'h80, 1'b0, 1'b1})
      $display("FAIL after_reset: got sum=%h co=%b ov=%b done_at=%0d want sum=80 co=0 ov=1 at 8",
               if8.sum, if8.carry_out, if8.overflow, lat);
    else pass_cnt++;
    tick();
    rst = 1'b1; if8.start = 1'b1; if8.a = 8'hFF; if8.b = 8'hFF;
    tick();
    rst = 1'b0; if8.start = 1'b0;
    tick();
    total_cnt++;
    if (if8.busy !== 1'b0 || if8.sum !== 8'h00)
      $display("FAIL rst_start: got busy=%b sum=%h want busy=0 sum=00", if8.busy, if8.sum);
    else pass_cnt++;
  endtask

  task automatic test_exhaustive4();
    int       bad, lat, dones;
    logic [4:0] full;
    logic     eov;
    bad = 0;
    for (int av = 0; av < 16; av++) begin
      for (int bv = 0; bv < 16; bv++) begin
        for (int cv = 0; cv < 2; cv++) begin
          if4.a = 4'(av); if4.b = 4'(bv); if4.carry_in = 1'(cv); if4.start = 1'b1;
          tick();
          if4.start = 1'b0;
          lat = -1;
          dones = 0;
          for (int j = 0; j < 20; j++) begin
            if (if4.done) begin lat = j; dones++; break; end
            tick();
          end
          full = 5'(av + bv + cv);
          eov  = (av[3] == bv[3]) && (full[3] != av[3]);
          tick();
          if (if4.done) dones++;
          if (lat !== 4 || dones !== 1 ||
              {if4.carry_out, if4.sum, if4.overflow} !== {full, eov}) begin
            if (bad < 5)
              $display("FAIL w4 %h+%h+%0d: got co=%b sum=%h ov=%b done_at=%0d pulses=%0d want co=%b sum=%h ov=%b",
                       av[3:0], bv[3:0], cv, if4.carry_out, if4.sum, if4.overflow, lat, dones,
                       full[4], full[3:0], eov);
            bad++;
          end
        end
      end
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL exhaustive4: got %0d bad ops want 0", bad);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.carry_in = 1'b0;
    if4.start = 1'b0; if4.a = '0; if4.b = '0; if4.carry_in = 1'b0;
    test_reset();
    test_vectors();
    test_start_ignored();
    test_operand_change();
    test_back_to_back();
    test_reset_mid_op();
    test_exhaustive4();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
